vending_fsm_param: RTL and testbench
====================================

// Module: vending_fsm_param
// PURPOSE
//  Parametrised successor to the gate-level vending FSM. Accepts three coin
//  denominations and accumulates credit up to a cap. Vends one of NUM_ITEMS
//  products at per-item prices and returns change.
//  Sits between the coin/keypad front end and the dispenser/change hopper drivers.
// PARAMETERS
//  NUM_ITEMS   4    number of selectable products (>=2)
//  CREDIT_W    8    width of credit/change datapath
//  PRICE_BASE  15   price of item 0 (credit units)
//  PRICE_STEP  5    price(i) = PRICE_BASE + i*PRICE_STEP; every price <= CREDIT_MAX
//  COIN0       5    value of coin_type 0
//  COIN1       10   value of coin_type 1
//  COIN2       25   value of coin_type 2
//  CREDIT_MAX  200  credit ceiling, < 2**CREDIT_W
//  STOCK_INIT  8    per-item stock after reset (STOCK_COUNT_EN only)
// PORTS
//  clock          in   1          system clock, rising edge
//  reset          in   1          asynchronous, active-low reset
//  coin_valid     in   1          coin present this cycle
//  coin_type      in   2          0/1/2 = COIN0/1/2, 3 = invalid
//  sel_valid      in   1          product selection strobe
//  sel_item       in   IW         item index, IW = $clog2(NUM_ITEMS)
//  cancel         in   1          refund request
//  credit         out  CREDIT_W   current accumulated credit
//  dispense       out  1          one-cycle vend pulse
//  dispense_item  out  IW         item vended; valid only with dispense
//  change_valid   out  1          one-cycle change pulse
//  change_amt     out  CREDIT_W   change value; 0 when change_valid=0
//  coin_reject    out  1          one-cycle pulse: coin returned to user
//  busy           out  1          high in VEND/REFUND
// BEHAVIOUR
//  - States: IDLE (credit=0), COLLECT (credit>0), VEND, REFUND. All outputs registered.
//  - Reset (reset=0): state=IDLE. All outputs are 0 immediately. Any in-flight credit is lost.
//  - Inputs sampled at edge N; the response appears after edge N (1-cycle latency).
//  - Same-cycle priority: cancel > sel_valid > coin_valid.
//    A coin in the same cycle as an accepted cancel/sel is rejected.
//  - Coin in IDLE/COLLECT: if coin_type!=3 and credit+value<=CREDIT_MAX,
//    then credit+=value and state=COLLECT. Otherwise coin_reject=1 for 1 cycle and credit is unchanged.
//  - Selection in IDLE/COLLECT with sel_item<NUM_ITEMS and credit>=price(sel_item):
//    next cycle state=VEND, dispense=1, dispense_item=sel_item, credit=0.
//    If credit>price: change_valid=1 and change_amt=credit-price.
//  - Selection with insufficient credit or out-of-range item: ignored; no pulses, credit kept.
//  - cancel in COLLECT: next cycle state=REFUND, change_valid=1, change_amt=credit, credit=0.
//    cancel in IDLE: no effect.
//  - VEND/REFUND last exactly 1 cycle, then IDLE.
//    While busy: coins rejected (coin_reject pulse), sel/cancel ignored.
//  - Arithmetic in CREDIT_W+1 bits internally; credit never exceeds CREDIT_MAX.
// CONFIGURATION
//  STOCK_COUNT_EN defined:
//    - Adds output sold_out [NUM_ITEMS-1:0].
//    - Adds per-item stock counters, loaded with STOCK_INIT at reset.
//    - A counter decrements on each dispense of its item.
//    - sold_out[i]=1 while stock[i]==0.
//    - A selection of a sold-out item is ignored, and credit is kept.
//  STOCK_COUNT_EN undefined: unlimited stock, no sold_out port, no counters.
// TESTING
//  1 reset low 100ns; coin 0, coin 1, sel 0 -> credit 5 then 15; dispense=1 item 0, change_valid=0, credit=0.
//  2 coin 2 (25), sel 1 (price 20) -> dispense item 1; change_valid=1, change_amt=5; IDLE after 1 busy cycle.
//  3 coin 1, cancel -> change_valid=1, change_amt=10, dispense=0; credit=0; a coin during REFUND gets coin_reject.
//  4 coins to credit 200, coin 0 -> coin_reject=1, credit stays 200; coin_type 3 -> coin_reject, credit unchanged.
//  5 credit 30, reset pulsed low mid-cycle -> credit=0 and outputs 0 before next edge; sel 3 with credit 5 -> ignored.
//  6 STOCK_COUNT_EN, STOCK_INIT=2: three buys of item 0 -> third ignored, sold_out[0]=1, credit retained.

Source files
------------

// File: rtl/vending_fsm_param.sv
`default_nettype none
// ============================================================================
//  Module      : vending_fsm_param
//  Description : Parametrised vending controller. Accumulates coin credit up
//                to CREDIT_MAX, vends one of NUM_ITEMS products priced
//                PRICE_BASE + i*PRICE_STEP, returns change, refunds on cancel.
//                Optional macro STOCK_COUNT_EN adds per-item stock counters
//                and a sold_out output.
//  Revision    : 1.0  initial release
// ============================================================================
module vending_fsm_param #(
  parameter int NUM_ITEMS  = 4,
  parameter int CREDIT_W   = 8,
  parameter int PRICE_BASE = 15,
  parameter int PRICE_STEP = 5,
  parameter int COIN0      = 5,
  parameter int COIN1      = 10,
  parameter int COIN2      = 25,
  parameter int CREDIT_MAX = 200,
  parameter int STOCK_INIT = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         coin_valid,
  input  logic [1:0]                   coin_type,
  input  logic                         sel_valid,
  input  logic [$clog2(NUM_ITEMS)-1:0] sel_item,
  input  logic                         cancel,
  output logic [CREDIT_W-1:0]          credit,
  output logic                         dispense,
  output logic [$clog2(NUM_ITEMS)-1:0] dispense_item,
  output logic                         change_valid,
  output logic [CREDIT_W-1:0]          change_amt,
  output logic                         coin_reject,
  output logic                         busy
`ifdef STOCK_COUNT_EN
  ,
  output logic [NUM_ITEMS-1:0]         sold_out
`endif
);

  localparam int IW  = $clog2(NUM_ITEMS);
  localparam int CW1 = CREDIT_W + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_VEND    = 2'd2;
  localparam logic [1:0] S_REFUND  = 2'd3;

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [CREDIT_W-1:0] credit_nxt;
  logic                dispense_nxt;
  logic [IW-1:0]       item_nxt;
  logic                change_valid_nxt;
  logic [CREDIT_W-1:0] change_amt_nxt;
  logic                coin_reject_nxt;
  logic                busy_nxt;

  // Credit arithmetic carries one extra bit so coin sums cannot wrap
  logic [CW1-1:0]      credit_ext;
  logic [CW1-1:0]      coin_val;
  logic [CW1-1:0]      coin_sum;
  logic [CW1-1:0]      price;
  logic                coin_ok;
  logic                item_in_range;
  logic                item_avail;
  logic                cancel_ok;
  logic                sel_ok;

  assign credit_ext    = {1'b0, credit};
  assign coin_sum      = credit_ext + coin_val;
  assign price         = CW1'(PRICE_BASE + int'(sel_item) * PRICE_STEP);
  assign item_in_range = int'(sel_item) < NUM_ITEMS;
  assign coin_ok       = (coin_type != 2'd3) && (coin_sum <= CW1'(CREDIT_MAX));
  assign cancel_ok     = cancel && (state == S_COLLECT);
  assign sel_ok        = sel_valid && item_in_range && item_avail && (credit_ext >= price);

  // Map coin_type to its credit value; type 3 carries no value
  always_comb begin
    coin_val = '0;
    case (coin_type)
      2'd0:    coin_val = CW1'(COIN0);
      2'd1:    coin_val = CW1'(COIN1);
      2'd2:    coin_val = CW1'(COIN2);
      default: coin_val = '0;
    endcase
  end

`ifdef STOCK_COUNT_EN
  localparam int SW = (STOCK_INIT > 0) ? $clog2(STOCK_INIT + 1) : 1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ITEMS; gi++) begin : g_stock
      logic [SW-1:0] cnt;

      // Per-item stock: reload on reset, count down on each vend of this item
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          cnt <= SW'(STOCK_INIT);
        end else if (dispense_nxt && (item_nxt == IW'(gi))) begin
          cnt <= cnt - SW'(1);
        end
      end

      assign sold_out[gi] = (cnt == '0);
    end
  endgenerate

  // Selected item is available only while its counter is non-zero
  always_comb begin
    item_avail = 1'b0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (int'(sel_item) == i) item_avail = !sold_out[i];
    end
  end
`else
  assign item_avail = 1'b1;
`endif

  // Next-state and next-output decode; priority cancel > select > coin
  always_comb begin
    state_nxt        = state;
    credit_nxt       = credit;
    dispense_nxt     = 1'b0;
    item_nxt         = '0;
    change_valid_nxt = 1'b0;
    change_amt_nxt   = '0;
    coin_reject_nxt  = 1'b0;
    busy_nxt         = 1'b0;
    case (state)
      S_VEND, S_REFUND: begin
        // Single busy cycle: everything but coin rejection is ignored
        state_nxt       = S_IDLE;
        credit_nxt      = '0;
        coin_reject_nxt = coin_valid;
      end
      default: begin
        if (cancel_ok) begin
          state_nxt        = S_REFUND;
          change_valid_nxt = 1'b1;
          change_amt_nxt   = credit;
          credit_nxt       = '0;
          busy_nxt         = 1'b1;
          coin_reject_nxt  = coin_valid;
        end else if (sel_ok) begin
          state_nxt       = S_VEND;
          dispense_nxt    = 1'b1;
          item_nxt        = sel_item;
          credit_nxt      = '0;
          busy_nxt        = 1'b1;
          coin_reject_nxt = coin_valid;
          if (credit_ext > price) begin
            change_valid_nxt = 1'b1;
            change_amt_nxt   = CREDIT_W'(credit_ext - price);
          end
        end else if (coin_valid) begin
          if (coin_ok) begin
            credit_nxt = coin_sum[CREDIT_W-1:0];
            state_nxt  = S_COLLECT;
          end else begin
            coin_reject_nxt = 1'b1;
          end
        end
      end
    endcase
  end

  // State and registered outputs; reset clears everything asynchronously
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      credit        <= '0;
      dispense      <= 1'b0;
      dispense_item <= '0;
      change_valid  <= 1'b0;
      change_amt    <= '0;
      coin_reject   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      credit        <= credit_nxt;
      dispense      <= dispense_nxt;
      dispense_item <= item_nxt;
      change_valid  <= change_valid_nxt;
      change_amt    <= change_amt_nxt;
      coin_reject   <= coin_reject_nxt;
      busy          <= busy_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vending_fsm_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vending_fsm_param
//  Description : Self-checking bench for vending_fsm_param: directed vector
//                table, hand-written corner sequences and a randomized run
//                against a credit-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vending_fsm_param;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_type = 2'd0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_item = 2'd0;
  logic       cancel = 1'b0;
  logic [7:0] credit;
  logic       dispense;
  logic [1:0] dispense_item;
  logic       change_valid;
  logic [7:0] change_amt;
  logic       coin_reject;
  logic       busy;
  localparam int TB_STOCK = 2;
`ifdef STOCK_COUNT_EN
  logic [3:0] sold_out;
`endif

  vending_fsm_param #(.STOCK_INIT(TB_STOCK)) dut (
    .clock         (clock),
    .reset         (reset),
    .coin_valid    (coin_valid),
    .coin_type     (coin_type),
    .sel_valid     (sel_valid),
    .sel_item      (sel_item),
    .cancel        (cancel),
    .credit        (credit),
    .dispense      (dispense),
    .dispense_item (dispense_item),
    .change_valid  (change_valid),
    .change_amt    (change_amt),
    .coin_reject   (coin_reject),
    .busy          (busy)
`ifdef STOCK_COUNT_EN
    ,
    .sold_out      (sold_out)
`endif
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       cv;
    logic [1:0] ct;
    logic       sv;
    logic [1:0] si;
    logic       cn;
    logic [7:0] e_credit;
    logic       e_disp;
    logic [1:0] e_item;
    logic       e_chv;
    logic [7:0] e_chg;
    logic       e_rej;
    logic       e_busy;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(input logic cv, input logic [1:0] ct, input logic sv,
                              input logic [1:0] si, input logic cn, input logic [7:0] cr,
                              input logic d, input logic [1:0] it, input logic chv,
                              input logic [7:0] chg, input logic rej, input logic bz);
    vec_t v;
    v.cv = cv; v.ct = ct; v.sv = sv; v.si = si; v.cn = cn;
    v.e_credit = cr; v.e_disp = d; v.e_item = it; v.e_chv = chv;
    v.e_chg = chg; v.e_rej = rej; v.e_busy = bz;
    return v;
  endfunction

  // Drive one cycle of inputs away from the edge, sample 1 time unit after it
  task automatic drive(input logic cv, input logic [1:0] ct, input logic sv,
                       input logic [1:0] si, input logic cn);
    @(negedge clock);
    coin_valid = cv; coin_type = ct; sel_valid = sv; sel_item = si; cancel = cn;
    @(posedge clock);
    #1;
  endtask

  task automatic check_out(input string name, input logic [7:0] cr, input logic d,
                           input logic [1:0] it, input logic chv, input logic [7:0] chg,
                           input logic rej, input logic bz);
    logic [21:0] act;
    logic [21:0] exp;
    act = {credit, dispense, (dispense ? dispense_item : 2'd0), change_valid, change_amt,
           coin_reject, busy};
    exp = {cr, d, (d ? it : 2'd0), chv, chg, rej, bz};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got credit=%0d disp=%b item=%0d chv=%b chg=%0d rej=%b busy=%b, expected credit=%0d disp=%b item=%0d chv=%b chg=%0d rej=%b busy=%b",
               name, credit, dispense, dispense_item, change_valid, change_amt, coin_reject, busy,
               cr, d, it, chv, chg, rej, bz);
    end
  endtask

  task automatic step(input string name, input logic cv, input logic [1:0] ct, input logic sv,
                      input logic [1:0] si, input logic cn, input logic [7:0] cr, input logic d,
                      input logic [1:0] it, input logic chv, input logic [7:0] chg,
                      input logic rej, input logic bz);
    drive(cv, ct, sv, si, cn);
    check_out(name, cr, d, it, chv, chg, rej, bz);
  endtask

  // ---------------- reference model (credit-level behaviour) ----------------
  int m_credit;
  bit m_busy;
  int m_stock[4];

  function automatic int item_price(input int i);
    return 15 + 5 * i;
  endfunction

  function automatic int coin_value(input int t);
    case (t)
      0: return 5;
      1: return 10;
      2: return 25;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_credit = 0;
    m_busy   = 1'b0;
    for (int i = 0; i < 4; i++) m_stock[i] = 8;
`ifdef STOCK_COUNT_EN
    for (int i = 0; i < 4; i++) m_stock[i] = TB_STOCK;
`endif
  endtask

  task automatic model_step(input bit cv, input int ct, input bit sv, input int si, input bit cn,
                            output int cr, output bit d, output int it, output bit chv,
                            output int chg, output bit rej, output bit bz);
    bit avail;
    d = 0; it = 0; chv = 0; chg = 0; rej = 0;
    avail = 1'b1;
`ifdef STOCK_COUNT_EN
    avail = (m_stock[si] > 0);
`endif
    if (m_busy) begin
      m_busy = 1'b0;
      rej = cv;
    end else if (cn && m_credit > 0) begin
      chv = 1; chg = m_credit; m_credit = 0; m_busy = 1'b1; rej = cv;
    end else if (sv && si < 4 && avail && m_credit >= item_price(si)) begin
      d = 1; it = si;
      if (m_credit > item_price(si)) begin
        chv = 1; chg = m_credit - item_price(si);
      end
      m_credit = 0; m_busy = 1'b1; rej = cv;
      m_stock[si] = m_stock[si] - 1;
    end else if (cv) begin
      if (coin_value(ct) >= 0 && m_credit + coin_value(ct) <= 200)
        m_credit = m_credit + coin_value(ct);
      else
        rej = 1;
    end
    cr = m_credit;
    bz = m_busy;
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b0;
    coin_valid = 0; sel_valid = 0; cancel = 0;
    @(negedge clock);
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    int mcr, mit, mchg;
    bit md, mchv, mrej, mbz;
    logic cv, sv, cn;
    logic [1:0] ct, si;

    // Directed table: purchases, change, refund, busy rejection, priorities
    tbl[0]  = mk(1, 0, 0, 0, 0,   5, 0, 0, 0,  0, 0, 0);
    tbl[1]  = mk(1, 1, 0, 0, 0,  15, 0, 0, 0,  0, 0, 0);
    tbl[2]  = mk(0, 0, 1, 0, 0,   0, 1, 0, 0,  0, 0, 1);
    tbl[3]  = mk(0, 0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0);
    tbl[4]  = mk(1, 2, 0, 0, 0,  25, 0, 0, 0,  0, 0, 0);
    tbl[5]  = mk(0, 0, 1, 1, 0,   0, 1, 1, 1,  5, 0, 1);
    tbl[6]  = mk(0, 0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0);
    tbl[7]  = mk(1, 1, 0, 0, 0,  10, 0, 0, 0,  0, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0, 1,   0, 0, 0, 1, 10, 0, 1);
    tbl[9]  = mk(1, 0, 0, 0, 0,   0, 0, 0, 0,  0, 1, 0);
    tbl[10] = mk(0, 0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0);
    tbl[11] = mk(1, 0, 0, 0, 0,   5, 0, 0, 0,  0, 0, 0);
    tbl[12] = mk(0, 0, 1, 3, 0,   5, 0, 0, 0,  0, 0, 0);
    tbl[13] = mk(1, 3, 0, 0, 0,   5, 0, 0, 0,  0, 1, 0);
    tbl[14] = mk(1, 1, 0, 0, 1,   0, 0, 0, 1,  5, 1, 1);
    tbl[15] = mk(0, 0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0);
    tbl[16] = mk(1, 0, 0, 0, 1,   5, 0, 0, 0,  0, 0, 0);
    tbl[17] = mk(1, 1, 1, 0, 0,  15, 0, 0, 0,  0, 0, 0);
    tbl[18] = mk(1, 2, 1, 0, 0,   0, 1, 0, 0,  0, 1, 1);
    tbl[19] = mk(0, 0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0);

    // Reset held low 100ns; outputs must already be zero
    #50;
    check_out("reset_low", 0, 0, 0, 0, 0, 0, 0);
`ifdef STOCK_COUNT_EN
    checks++;
    if (sold_out !== 4'b0000) begin
      errors++;
      $display("FAIL reset_sold_out: got %b expected 0000", sold_out);
    end
`endif
    #50;
    @(negedge clock);
    reset = 1'b1;
    model_reset();

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].cv, tbl[i].ct, tbl[i].sv, tbl[i].si, tbl[i].cn);
      check_out($sformatf("vec%0d", i), tbl[i].e_credit, tbl[i].e_disp, tbl[i].e_item,
                tbl[i].e_chv, tbl[i].e_chg, tbl[i].e_rej, tbl[i].e_busy);
    end

    // Fill to the credit ceiling, then overflow and invalid coins are rejected
    for (int i = 0; i < 8; i++) drive(1, 2, 0, 0, 0);
    check_out("cap_200", 200, 0, 0, 0, 0, 0, 0);
    step("cap_overflow", 1, 0, 0, 0, 0, 200, 0, 0, 0, 0, 1, 0);
    step("cap_invalid",  1, 3, 0, 0, 0, 200, 0, 0, 0, 0, 1, 0);
    step("cap_refund",   0, 0, 0, 0, 1,   0, 0, 0, 1, 200, 0, 1);
    step("cap_idle",     0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset mid-cycle clears credit before the next edge
    drive(1, 2, 0, 0, 0);
    step("pre_rst_30", 1, 0, 0, 0, 0, 30, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    coin_valid = 0;
    #1 reset = 1'b0;
    #1;
    check_out("async_rst", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    step("post_rst_coin", 1, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0);
    step("sel3_low",      0, 0, 1, 3, 0, 5, 0, 0, 0, 0, 0, 0);
    step("post_rst_cxl",  0, 0, 0, 0, 1, 0, 0, 0, 1, 5, 0, 1);
    step("post_rst_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

`ifdef STOCK_COUNT_EN
    // Stock of item 0 runs out after two sales; third selection keeps credit
    for (int k = 0; k < 2; k++) begin
      drive(1, 2, 0, 0, 0);
      step("stock_buy", 0, 0, 1, 0, 0, 0, 1, 0, 1, 10, 0, 1);
      drive(0, 0, 0, 0, 0);
    end
    drive(1, 2, 0, 0, 0);
    step("stock_out_sel", 0, 0, 1, 0, 0, 25, 0, 0, 0, 0, 0, 0);
    checks++;
    if (sold_out !== 4'b0001) begin
      errors++;
      $display("FAIL sold_out: got %b expected 0001", sold_out);
    end
    step("stock_cxl", 0, 0, 0, 0, 1, 0, 0, 0, 1, 25, 0, 1);
`endif

    // Randomized run against the reference model
    pulse_reset();
    for (int n = 0; n < 600; n++) begin
      cv = ($urandom_range(0, 99) < 55);
      ct = 2'($urandom_range(0, 3));
      sv = ($urandom_range(0, 99) < 25);
      si = 2'($urandom_range(0, 3));
      cn = ($urandom_range(0, 99) < 8);
      drive(cv, ct, sv, si, cn);
      model_step(cv, int'(ct), sv, int'(si), cn, mcr, md, mit, mchv, mchg, mrej, mbz);
      check_out($sformatf("rand%0d", n), 8'(mcr), md, 2'(mit), mchv, 8'(mchg), mrej, mbz);
`ifdef STOCK_COUNT_EN
      begin
        logic [3:0] exp_so;
        for (int i = 0; i < 4; i++) exp_so[i] = (m_stock[i] == 0);
        checks++;
        if (sold_out !== exp_so) begin
          errors++;
          $display("FAIL rand_sold_out%0d: got %b expected %b", n, sold_out, exp_so);
        end
      end
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
